// File: rtl/bp_table_scheduler_pkg.sv
// Shared types and constants for the gshare counter-table scheduler.
package bp_table_scheduler_pkg;

    localparam int ADDR_WIDTH = 32;

    typedef enum logic {NOT_TAKEN = 1'b0, TAKEN = 1'b1} BranchOutcome;

    typedef enum logic [1:0] {S_INIT, S_RUN, S_UPD_WR} sched_state_t;

    localparam logic [1:0] CTR_WEAK_NT = 2'b01;

    // 2-bit saturating counter step
    function automatic logic [1:0] ctr_next(input logic [1:0] ctr, input BranchOutcome o);
        if (o == TAKEN) return (ctr == 2'b11) ? ctr : ctr + 2'd1;
        return (ctr == 2'b00) ? ctr : ctr - 2'd1;
    endfunction

endpackage

// File: rtl/bp_table_scheduler_fb_fifo.sv
// Small synchronous FIFO for resolved-branch feedback; a push into a full FIFO
// is kept when the head is popped in the same cycle.
module bp_fb_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  logic [W-1:0] push_data,
    input  logic         pop,
    output logic [W-1:0] head,
    output logic         full,
    output logic         empty
);
    localparam int PW = $clog2(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [PW-1:0] wr_ptr, rd_ptr;
    logic [PW:0]   count;
    logic          do_push, do_pop;

    assign empty   = (count == '0);
    assign full    = (count == (PW+1)'(DEPTH));
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign head    = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/bp_table_scheduler.sv
// Arbitrates the single-port gshare counter table between lookups, feedback
// updates and the post-reset sweep; owns the non-speculative global history.
module bp_table_scheduler
    import bp_table_scheduler_pkg::*;
#(
    parameter int INDEX_WIDTH = 10,
    parameter int GHR_WIDTH   = 10,
    parameter int FB_DEPTH    = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   i_req_valid,
    input  logic [ADDR_WIDTH-1:0]  i_req_pc,
    output logic                   o_req_ready,
    output logic                   o_pred_valid,
    output BranchOutcome           o_pred,
    input  logic                   i_fb_valid,
    input  logic [ADDR_WIDTH-1:0]  i_fb_pc,
    input  BranchOutcome           i_fb_outcome,
    output logic                   o_tbl_en,
    output logic                   o_tbl_we,
    output logic [INDEX_WIDTH-1:0] o_tbl_addr,
    output logic [1:0]             o_tbl_wdata,
    input  logic [1:0]             i_tbl_rdata,
    output logic                   o_init_busy,
    output logic                   o_fb_overflow
);
    localparam int FW = INDEX_WIDTH + 1;

    function automatic logic [INDEX_WIDTH-1:0] idx_of(input logic [ADDR_WIDTH-1:0] pc,
                                                      input logic [GHR_WIDTH-1:0]  g);
        return pc[INDEX_WIDTH+1:2] ^ INDEX_WIDTH'(g);
    endfunction

    sched_state_t           state;
    logic [INDEX_WIDTH-1:0] sweep_idx;
    logic [GHR_WIDTH-1:0]   ghr;
    logic                   pred_vld;
    BranchOutcome           pred_q;

    logic                   fifo_full, fifo_empty, fifo_push, fifo_pop;
    logic [FW-1:0]          fifo_head, fb_entry;
    logic [INDEX_WIDTH-1:0] head_idx;
    BranchOutcome           head_outcome;
    logic                   in_run, drain, lookup;

    assign head_idx     = fifo_head[FW-1:1];
    assign head_outcome = BranchOutcome'(fifo_head[0]);
    assign fb_entry     = {idx_of(i_fb_pc, ghr), i_fb_outcome == TAKEN};

    // A full FIFO outranks lookups; otherwise feedback only drains on idle cycles.
    assign in_run      = !rst && (state == S_RUN);
    assign drain       = in_run && (fifo_full || (!i_req_valid && !fifo_empty));
    assign lookup      = in_run && !fifo_full && i_req_valid;
    assign o_req_ready = lookup;
    assign fifo_pop    = !rst && (state == S_UPD_WR);
    assign fifo_push   = !rst && i_fb_valid;

    assign o_init_busy  = !rst && (state == S_INIT);
    assign o_pred_valid = pred_vld;
    assign o_pred       = pred_vld ? BranchOutcome'(i_tbl_rdata[1]) : pred_q;

    logic unused_pc_bits;
    assign unused_pc_bits = ^{i_req_pc[1:0], i_req_pc[ADDR_WIDTH-1:INDEX_WIDTH+2],
                              i_fb_pc[1:0],  i_fb_pc[ADDR_WIDTH-1:INDEX_WIDTH+2]};

    bp_fb_fifo #(.DEPTH(FB_DEPTH), .W(FW)) u_fb_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (fifo_push),
        .push_data (fb_entry),
        .pop       (fifo_pop),
        .head      (fifo_head),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    always_comb begin
        o_tbl_en    = 1'b0;
        o_tbl_we    = 1'b0;
        o_tbl_addr  = '0;
        o_tbl_wdata = '0;
        if (!rst) begin
            unique case (state)
                S_INIT: begin
                    o_tbl_en    = 1'b1;
                    o_tbl_we    = 1'b1;
                    o_tbl_addr  = sweep_idx;
                    o_tbl_wdata = CTR_WEAK_NT;
                end
                S_RUN: begin
                    if (drain) begin
                        o_tbl_en   = 1'b1;
                        o_tbl_addr = head_idx;
                    end else if (lookup) begin
                        o_tbl_en   = 1'b1;
                        o_tbl_addr = idx_of(i_req_pc, ghr);
                    end
                end
                S_UPD_WR: begin
                    o_tbl_en    = 1'b1;
                    o_tbl_we    = 1'b1;
                    o_tbl_addr  = head_idx;
                    o_tbl_wdata = ctr_next(i_tbl_rdata, head_outcome);
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= S_INIT;
            sweep_idx     <= '0;
            ghr           <= '0;
            o_fb_overflow <= 1'b0;
            pred_vld      <= 1'b0;
            pred_q        <= NOT_TAKEN;
        end else begin
            pred_vld <= lookup;
            if (pred_vld) pred_q <= o_pred;
            if (i_fb_valid) begin
                ghr <= {ghr[GHR_WIDTH-2:0], i_fb_outcome == TAKEN};
                if (fifo_full && !fifo_pop) o_fb_overflow <= 1'b1;
            end
            case (state)
                S_INIT: begin
                    sweep_idx <= sweep_idx + 1'b1;
                    if (&sweep_idx) state <= S_RUN;
                end
                S_RUN:    if (drain) state <= S_UPD_WR;
                S_UPD_WR: state <= S_RUN;
                default:  state <= S_INIT;
            endcase
        end
    end

endmodule
